// File: rtl/lamp_sqrt_issue_ctrl.sv
// lamp_sqrt_issue_ctrl: decodes a bfloat16-style operand, issues it to the iterative sqrt core,
// then normalises, rounds (nearest-even) and repacks the core's Q2.14 result.
module lamp_sqrt_issue_ctrl #(
    parameter int E_DW    = 8,
    parameter int F_DW    = 7,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [E_DW+F_DW:0]   op_i,
    input  logic                 inv_i,
    output logic                 doSqrt_o,
    output logic [F_DW:0]        s_o,
    output logic                 is_exp_odd_o,
    output logic                 invSqrt_o,
    output logic                 special_case_o,
    input  logic                 core_valid_i,
    input  logic [15:0]          core_res_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [E_DW+F_DW:0]   res_o,
    output logic                 err_o
);
    localparam int W  = 1 + E_DW + F_DW;
    localparam int XW = E_DW + 4;
    localparam int NW = 16 + F_DW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic signed [XW-1:0] BIAS = XW'((1 << (E_DW - 1)) - 1);
    localparam logic signed [XW-1:0] OFS  = XW'((1 << (E_DW - 1)) - 1 - 14);
    localparam logic signed [XW-1:0] EMAX = XW'((1 << E_DW) - 1);
    localparam logic [W-1:0] QNAN = {1'b0, {E_DW{1'b1}}, 1'b1, {(F_DW-1){1'b0}}};
    localparam logic [W-1:0] INF  = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ROUND, OUT} state_t;
    state_t state, state_n;

    logic [W-1:0] op_r, res_r, spec_val, rnd_res;
    logic inv_r, err_r;
    logic [15:0] core_r;
    logic [CW-1:0] cnt;

    logic sgn, is_nan, is_inf, is_zero, special;
    logic [E_DW-1:0] ex;
    logic [F_DW-1:0] fr;
    logic signed [XW-1:0] e, eb, ex_r;

    assign sgn     = op_r[W-1];
    assign ex      = op_r[W-2 -: E_DW];
    assign fr      = op_r[F_DW-1:0];
    assign is_nan  = &ex && |fr;
    assign is_inf  = &ex && !(|fr);
    assign is_zero = !(|ex) && !(|fr);
    assign special = is_nan | is_inf | is_zero | sgn;
    // subnormals use the minimum exponent, as the hidden bit is carried in s_o
    assign e  = $signed(XW'(ex == '0 ? E_DW'(1) : ex)) - BIAS;
    assign eb = inv_r ? -(e >>> 1) : (e >>> 1);
    assign spec_val = (is_nan || (sgn && !is_zero)) ? QNAN :
                      is_inf ? (inv_r ? '0 : INF) :
                      {sgn, inv_r ? INF[W-2:0] : {(W-1){1'b0}}};

    logic [3:0] p;
    logic [NW-2:0] norm;
    logic [F_DW+1:0] mant;
    logic [F_DW-1:0] frac_o;
    logic g, st, up;

    always_comb begin
        p = '0;
        for (int i = 0; i < 16; i++) if (core_r[i]) p = 4'(i);
    end

    // leading one shifted off the top; what remains is fraction, guard, sticky
    assign norm   = (NW-1)'({core_r, {(F_DW+1){1'b0}}} << (4'd15 - p));
    assign g      = norm[NW-2-F_DW];
    assign st     = |norm[NW-3-F_DW:0];
    assign up     = g & (st | norm[NW-1-F_DW]);
    assign mant   = {2'b01, norm[NW-2 -: F_DW]} + (F_DW+2)'(up);
    assign frac_o = mant[F_DW+1] ? mant[F_DW:1] : mant[F_DW-1:0];
    assign ex_r   = eb + $signed(XW'(p)) + OFS + $signed(XW'(mant[F_DW+1]));
    assign rnd_res = (!ex_r[XW-1] && ex_r >= EMAX) ? INF :
                     (ex_r[XW-1] || ex_r == '0) ? '0 : {1'b0, ex_r[E_DW-1:0], frac_o};

    always_comb begin
        state_n        = state;
        in_ready_o     = (state == IDLE) && !rst;
        doSqrt_o       = state == ISSUE;
        s_o            = doSqrt_o ? {|ex, fr} : '0;
        is_exp_odd_o   = doSqrt_o & e[0];
        invSqrt_o      = doSqrt_o & inv_r;
        special_case_o = doSqrt_o & special;
        out_valid_o    = state == OUT;
        res_o          = out_valid_o ? res_r : '0;
        err_o          = out_valid_o & err_r;
        case (state)
            IDLE:    state_n = in_valid_i ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = core_valid_i ? ROUND : (cnt == CW'(TIMEOUT - 1)) ? OUT : WAIT;
            ROUND:   state_n = OUT;
            OUT:     state_n = out_ready_i ? IDLE : OUT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_r   <= '0;
            inv_r  <= 1'b0;
            core_r <= '0;
            cnt    <= '0;
            res_r  <= '0;
            err_r  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid_i) begin
                op_r  <= op_i;
                inv_r <= inv_i;
            end
            if (state == ISSUE) cnt <= '0;
            if (state == WAIT) cnt <= cnt + 1'b1;
            if (state == WAIT && core_valid_i) core_r <= core_res_i;
            if (state == WAIT && !core_valid_i && cnt == CW'(TIMEOUT - 1)) begin
                res_r <= QNAN;
                err_r <= 1'b1;
            end
            if (state == ROUND) begin
                res_r <= special ? spec_val : (core_r == '0) ? QNAN : rnd_res;
                err_r <= !special && core_r == '0;
            end
        end
    end
endmodule

// File: tb/tb_lamp_sqrt_issue_ctrl.sv
// tb_lamp_sqrt_issue_ctrl: directed vector table, reset/timeout sequences and random ops
// checked against a real-arithmetic reference model.
module tb_lamp_sqrt_issue_ctrl;
    localparam int TO = 16;

    logic clk = 1'b0, rst, in_valid_i, in_ready_o, inv_i, doSqrt_o, is_exp_odd_o, invSqrt_o;
    logic special_case_o, core_valid_i, out_valid_o, out_ready_i, err_o;
    logic [15:0] op_i, core_res_i, res_o;
    logic [7:0] s_o;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    lamp_sqrt_issue_ctrl #(.E_DW(8), .F_DW(7), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .op_i(op_i),
        .inv_i(inv_i), .doSqrt_o(doSqrt_o), .s_o(s_o), .is_exp_odd_o(is_exp_odd_o),
        .invSqrt_o(invSqrt_o), .special_case_o(special_case_o), .core_valid_i(core_valid_i),
        .core_res_i(core_res_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .res_o(res_o), .err_o(err_o)
    );

    typedef struct {
        logic [15:0] op;
        logic        inv;
        logic [15:0] core;
        int          lat;
        int          hold;
        logic [7:0]  s;
        logic        odd;
        logic        spec;
        logic [15:0] res;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [15:0] model_round(input logic [15:0] core, input int eb);
        real m, sc, rem;
        int ex, f;
        m = core;
        ex = eb - 14;
        while (m >= 2.0) begin m = m / 2.0; ex++; end
        while (m < 1.0) begin m = m * 2.0; ex--; end
        sc = m * 128.0;
        f = int'($floor(sc));
        rem = sc - real'(f);
        if (rem > 0.5 || (rem == 0.5 && f % 2 == 1)) f++;
        if (f == 256) begin f = 128; ex++; end
        ex = ex + 127;
        if (ex >= 255) return 16'h7F80;
        if (ex <= 0) return 16'h0000;
        return {1'b0, ex[7:0], f[6:0]};
    endfunction

    function automatic vec_t model(input logic [15:0] op, input logic inv, input logic [15:0] core,
                                   input int lat, input int hold);
        vec_t v;
        int ex, e, eb;
        logic sg, nan, inf, zero;
        ex = int'(op[14:7]);
        sg = op[15];
        e = (ex == 0 ? 1 : ex) - 127;
        eb = (e - (e & 1)) / 2;
        if (inv) eb = -eb;
        nan = ex == 255 && op[6:0] != 0;
        inf = ex == 255 && op[6:0] == 0;
        zero = ex == 0 && op[6:0] == 0;
        v.op = op; v.inv = inv; v.core = core; v.lat = lat; v.hold = hold;
        v.s = {ex != 0, op[6:0]};
        v.odd = e[0];
        v.spec = nan || inf || zero || (sg && !zero);
        v.err = 1'b0;
        if (lat == 0) begin v.res = 16'h7FC0; v.err = 1'b1; end
        else if (nan || (sg && !zero)) v.res = 16'h7FC0;
        else if (inf) v.res = inv ? 16'h0000 : 16'h7F80;
        else if (zero) v.res = {sg, inv ? 15'h7F80 : 15'h0000};
        else if (core == 0) begin v.res = 16'h7FC0; v.err = 1'b1; end
        else v.res = model_round(core, eb);
        return v;
    endfunction

    task automatic issue_op(input logic [15:0] op, input logic inv, input string nm);
        int n = 0;
        while (!in_ready_o && n < 20) begin @(negedge clk); n++; end
        chk({nm, ".in_ready"}, 32'(in_ready_o), 32'd1);
        op_i = op; inv_i = inv; in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0; op_i = 16'($urandom); inv_i = 1'($urandom);
    endtask

    task automatic run_op(input vec_t v, input string nm);
        int w = 0;
        issue_op(v.op, v.inv, nm);
        core_valid_i = 1'b1; core_res_i = 16'($urandom);
        chk({nm, ".do_sqrt"}, 32'(doSqrt_o), 32'd1);
        chk({nm, ".s"}, 32'(s_o), 32'(v.s));
        chk({nm, ".odd"}, 32'(is_exp_odd_o), 32'(v.odd));
        chk({nm, ".inv"}, 32'(invSqrt_o), 32'(v.inv));
        chk({nm, ".special"}, 32'(special_case_o), 32'(v.spec));
        chk({nm, ".busy"}, 32'(in_ready_o), 32'd0);
        while (!out_valid_o && w < 3 * TO) begin
            @(negedge clk);
            w++;
            core_valid_i = (w == v.lat);
            core_res_i = (w == v.lat) ? v.core : 16'($urandom);
            if (w == 1) chk({nm, ".quiet"}, 32'({doSqrt_o, s_o, is_exp_odd_o, invSqrt_o, special_case_o, in_ready_o}), 32'd0);
        end
        chk({nm, ".out_valid"}, 32'(out_valid_o), 32'd1);
        chk({nm, ".latency"}, 32'(w), 32'(v.lat == 0 ? TO + 1 : v.lat + 2));
        chk({nm, ".res"}, 32'(res_o), 32'(v.res));
        chk({nm, ".err"}, 32'(err_o), 32'(v.err));
        core_valid_i = 1'b0;
        for (int k = 0; k < v.hold; k++) begin
            @(negedge clk);
            core_valid_i = 1'($urandom); core_res_i = 16'($urandom);
            chk({nm, ".hold"}, 32'({out_valid_o, in_ready_o, err_o, res_o}), 32'({1'b1, 1'b0, v.err, v.res}));
        end
        core_valid_i = 1'b0; out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk({nm, ".release"}, 32'({out_valid_o, in_ready_o}), 32'b01);
    endtask

    vec_t tbl[$];

    initial begin
        tbl.push_back('{16'h4080, 1'b0, 16'h4000, 5, 1,  8'h80, 1'b0, 1'b0, 16'h4000, 1'b0});
        tbl.push_back('{16'h4080, 1'b1, 16'h4000, 5, 0,  8'h80, 1'b0, 1'b0, 16'h3F00, 1'b0});
        tbl.push_back('{16'h4000, 1'b0, 16'h5A82, 3, 0,  8'h80, 1'b1, 1'b0, 16'h3FB5, 1'b0});
        tbl.push_back('{16'h3F80, 1'b0, 16'h40C0, 2, 0,  8'h80, 1'b0, 1'b0, 16'h3F82, 1'b0});
        tbl.push_back('{16'hBF80, 1'b0, 16'h1234, 1, 0,  8'h80, 1'b0, 1'b1, 16'h7FC0, 1'b0});
        tbl.push_back('{16'h8000, 1'b1, 16'h0000, 1, 0,  8'h00, 1'b0, 1'b1, 16'hFF80, 1'b0});
        tbl.push_back('{16'h8000, 1'b0, 16'h0000, 1, 0,  8'h00, 1'b0, 1'b1, 16'h8000, 1'b0});
        tbl.push_back('{16'h0000, 1'b0, 16'h4000, 1, 0,  8'h00, 1'b0, 1'b1, 16'h0000, 1'b0});
        tbl.push_back('{16'h7F80, 1'b0, 16'h5555, 1, 0,  8'h80, 1'b0, 1'b1, 16'h7F80, 1'b0});
        tbl.push_back('{16'h7F80, 1'b1, 16'h5555, 1, 0,  8'h80, 1'b0, 1'b1, 16'h0000, 1'b0});
        tbl.push_back('{16'h7FC1, 1'b0, 16'h4000, 1, 0,  8'hC1, 1'b0, 1'b1, 16'h7FC0, 1'b0});
        tbl.push_back('{16'h4080, 1'b0, 16'h0000, 4, 0,  8'h80, 1'b0, 1'b0, 16'h7FC0, 1'b1});
        tbl.push_back('{16'h3F80, 1'b0, 16'h7FC0, 2, 0,  8'h80, 1'b0, 1'b0, 16'h4000, 1'b0});
        tbl.push_back('{16'h3F80, 1'b0, 16'h8180, 2, 0,  8'h80, 1'b0, 1'b0, 16'h4002, 1'b0});
        tbl.push_back('{16'h3F80, 1'b0, 16'h0003, 1, 0,  8'h80, 1'b0, 1'b0, 16'h3940, 1'b0});
        tbl.push_back('{16'h4080, 1'b0, 16'h4000, 0, 10, 8'h80, 1'b0, 1'b0, 16'h7FC0, 1'b1});

        rst = 1'b1; in_valid_i = 1'b0; op_i = '0; inv_i = 1'b0;
        core_valid_i = 1'b0; core_res_i = '0; out_ready_i = 1'b0;
        #12;
        chk("reset.outputs", 32'({in_ready_o, doSqrt_o, s_o, is_exp_odd_o, invSqrt_o, special_case_o, out_valid_o, err_o}), 32'd0);
        chk("reset.res", 32'(res_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("reset.release_ready", 32'(in_ready_o), 32'd1);

        for (int i = 0; i < tbl.size(); i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // reset in WAIT, then a stale core pulse during reset must be forgotten
        issue_op(16'h4080, 1'b0, "rst_wait");
        repeat (4) @(negedge clk);
        chk("rst_wait.busy", 32'(in_ready_o), 32'd0);
        #2 rst = 1'b1;
        #1 chk("rst_wait.async", 32'({in_ready_o, doSqrt_o, s_o, out_valid_o, err_o, res_o}), 32'd0);
        @(negedge clk);
        core_valid_i = 1'b1; core_res_i = 16'h4000;
        @(negedge clk);
        core_valid_i = 1'b0; rst = 1'b0;
        #1 chk("rst_wait.idle", 32'({in_ready_o, out_valid_o}), 32'b10);
        run_op(tbl[0], "after_rst");

        // reset while a result is presented
        begin
            int w = 0;
            issue_op(16'h3F80, 1'b0, "rst_out");
            while (!out_valid_o && w < 3 * TO) begin
                @(negedge clk);
                w++;
                core_valid_i = (w == 1); core_res_i = 16'h4000;
            end
            core_valid_i = 1'b0;
            chk("rst_out.valid", 32'({out_valid_o, res_o}), 32'({1'b1, 16'h3F80}));
            #2 rst = 1'b1;
            #1 chk("rst_out.async", 32'({in_ready_o, out_valid_o, err_o, res_o}), 32'd0);
            @(negedge clk);
            rst = 1'b0;
        end

        for (int i = 0; i < 40; i++) begin
            logic [15:0] op, core;
            op = 16'($urandom);
            if ($urandom_range(0, 1) == 0) op[15] = 1'b0;
            if ($urandom_range(0, 7) == 0) op[14:7] = $urandom_range(0, 1) == 0 ? 8'h00 : 8'hFF;
            core = $urandom_range(0, 7) == 0 ? 16'h0000 : 16'($urandom);
            run_op(model(op, 1'($urandom), core, $urandom_range(1, 8), $urandom_range(0, 3)), $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
